bp_stall_histogram: RTL and testbench

Synthesizable, multi-channel stall-attribution histogram, one channel per BlackParrot core. Each cycle, every channel receives a per-reason stall vector and an instret strobe. The block priority-encodes the vector, then increments one counter per (channel, reason), plus per-channel instret, cycle and unattributed counters. Results are read back over a valid/yumi read port, so stall breakdowns are available on silicon/FPGA without simulation-only file dumps.

---
 rtl/bp_stall_histogram.sv | 205 ++++++++++++++++++++
 tb/tb_bp_stall_histogram.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stall_histogram.sv
`default_nettype none
// ============================================================================
// Module   : bp_stall_histogram
// Purpose  : Multi-channel stall-attribution histogram, one channel per core.
//            Every cycle each enabled channel bumps its cycles counter, then
//            exactly one of: instret, the highest-priority (lowest-index)
//            stall reason, or the unattributed counter. All counters are read
//            back through a valid/yumi request/response port.
// Ports    : clk_i, reset_li      clock, asynchronous active-low reset
//            freeze_i[C]          per-channel freeze (delayed before use)
//            instret_i[C]         per-channel instruction-retired strobe
//            stall_reason_i[C*R]  channel c occupies bits [c*R +: R]
//            clear_i              synchronous clear of counters/overflow
//            rd_v_i/rd_ready_o    read request handshake
//            rd_chan_i/rd_addr_i  channel and counter index of the request
//                                 (0..R-1 reason, R unattributed,
//                                  R+1 instret, R+2 cycles)
//            rd_data_v_o/rd_data_o/rd_err_o/rd_yumi_i  read response
//            overflow_o[C]        sticky per-channel overflow flag
// Config   : BP_STALL_HIST_SATURATE_EN defined -> counters saturate at
//            all-ones and overflow flags on reaching all-ones; otherwise
//            counters wrap and overflow flags on a wrap.
// Revision : 1.0 - initial release
// ============================================================================
module bp_stall_histogram #(
    parameter int  num_channels_p  = 1,
    parameter int  num_reasons_p   = 32,
    parameter int  counter_width_p = 32,
    parameter int  freeze_delay_p  = 8,
    localparam int addr_width_lp   = $clog2(num_reasons_p + 3),
    localparam int chan_width_lp   = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_li,
    input  logic [num_channels_p-1:0]                 freeze_i,
    input  logic [num_channels_p-1:0]                 instret_i,
    input  logic [num_channels_p*num_reasons_p-1:0]   stall_reason_i,
    input  logic                                      clear_i,
    input  logic                                      rd_v_i,
    output logic                                      rd_ready_o,
    input  logic [chan_width_lp-1:0]                  rd_chan_i,
    input  logic [addr_width_lp-1:0]                  rd_addr_i,
    output logic                                      rd_data_v_o,
    output logic [counter_width_p-1:0]                rd_data_o,
    output logic                                      rd_err_o,
    input  logic                                      rd_yumi_i,
    output logic [num_channels_p-1:0]                 overflow_o
);

    // Counter layout within a channel: reasons first, then the three
    // per-channel bookkeeping counters.
    localparam int num_counters_lp = num_reasons_p + 3;
    localparam logic [counter_width_p-1:0] cnt_max_lp = '1;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [freeze_delay_p-1:0]   freeze_sr [num_channels_p];
    logic [num_channels_p-1:0]   count_en;
    logic [num_counters_lp-1:0]  inc       [num_channels_p];
    logic [counter_width_p-1:0]  cnt       [num_channels_p][num_counters_lp];
    logic [num_channels_p-1:0]   ovf_set;

    logic [counter_width_p-1:0]  rd_sel;
    logic                        rd_bad;
    logic                        rd_accept;

    // ------------------------------------------------------------------
    // Freeze delay lines. Reset fills them with ones so counting stays
    // off until freeze_delay_p consecutive unfrozen samples have passed.
    // The shift/OR form also works for a single-stage delay line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int c = 0; c < num_channels_p; c++) begin
                freeze_sr[c] <= '1;
            end
        end else begin
            for (int c = 0; c < num_channels_p; c++) begin
                freeze_sr[c] <= (freeze_sr[c] << 1) | freeze_delay_p'(freeze_i[c]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel increment vector: one bit per counter.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        logic [num_reasons_p-1:0] reasons;
        logic [num_reasons_p-1:0] lowest;
        logic                     none_set;

        assign reasons     = stall_reason_i[c*num_reasons_p +: num_reasons_p];
        // Two's-complement trick isolates the lowest set bit, which is the
        // highest-priority reason.
        assign lowest      = reasons & (~reasons + 1'b1);
        assign none_set    = ~|reasons;
        assign count_en[c] = ~|freeze_sr[c];

        // Retirement masks any stall attribution for the cycle.
        assign inc[c] = count_en[c]
                      ? {1'b1,                             // cycles
                         instret_i[c],                     // instret
                         ~instret_i[c] & none_set,         // unattributed
                         lowest & {num_reasons_p{~instret_i[c]}}}
                      : {num_counters_lp{1'b0}};
    end

    // ------------------------------------------------------------------
    // Overflow detection for the counters being bumped this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < num_channels_p; c++) begin
            ovf_set[c] = 1'b0;
            for (int k = 0; k < num_counters_lp; k++) begin
`ifdef BP_STALL_HIST_SATURATE_EN
                // Flag as soon as an increment lands on (or sits at) all-ones.
                if (inc[c][k] && ((cnt[c][k] == cnt_max_lp) ||
                                  (cnt[c][k] == cnt_max_lp - 1'b1))) begin
                    ovf_set[c] = 1'b1;
                end
`else
                // Flag when an all-ones counter is about to wrap to zero.
                if (inc[c][k] && (cnt[c][k] == cnt_max_lp)) begin
                    ovf_set[c] = 1'b1;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter bank and sticky overflow flags. Clear beats any increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int c = 0; c < num_channels_p; c++) begin
                for (int k = 0; k < num_counters_lp; k++) begin
                    cnt[c][k] <= '0;
                end
            end
            overflow_o <= '0;
        end else if (clear_i) begin
            for (int c = 0; c < num_channels_p; c++) begin
                for (int k = 0; k < num_counters_lp; k++) begin
                    cnt[c][k] <= '0;
                end
            end
            overflow_o <= '0;
        end else begin
            for (int c = 0; c < num_channels_p; c++) begin
                for (int k = 0; k < num_counters_lp; k++) begin
                    if (inc[c][k]) begin
`ifdef BP_STALL_HIST_SATURATE_EN
                        if (cnt[c][k] != cnt_max_lp) begin
                            cnt[c][k] <= cnt[c][k] + 1'b1;
                        end
`else
                        cnt[c][k] <= cnt[c][k] + 1'b1;
`endif
                    end
                end
            end
            overflow_o <= overflow_o | ovf_set;
        end
    end

    // ------------------------------------------------------------------
    // Read port. The mux compares against every legal (channel, index)
    // pair so an out-of-range request never indexes outside the bank.
    // ------------------------------------------------------------------
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            for (int k = 0; k < num_counters_lp; k++) begin
                if ((int'(rd_chan_i) == c) && (int'(rd_addr_i) == k)) begin
                    rd_sel = cnt[c][k];
                end
            end
        end
    end

    assign rd_bad     = (int'(rd_chan_i) >= num_channels_p) ||
                        (int'(rd_addr_i) >= num_counters_lp);
    assign rd_ready_o = ~rd_data_v_o | rd_yumi_i;
    assign rd_accept  = rd_v_i & rd_ready_o;

    // The response captures the pre-update counter value, so a read that
    // coincides with clear_i still returns the value being cleared.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            rd_data_v_o <= 1'b0;
            rd_data_o   <= '0;
            rd_err_o    <= 1'b0;
        end else if (rd_accept) begin
            rd_data_v_o <= 1'b1;
            rd_data_o   <= rd_bad ? '0 : rd_sel;
            rd_err_o    <= rd_bad;
        end else if (rd_yumi_i) begin
            rd_data_v_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_stall_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_stall_histogram
// Purpose  : Self-checking bench for bp_stall_histogram. A behavioural model
//            tracks counters as plain integers, freeze gating as a count of
//            consecutive unfrozen samples, and the read port as a single
//            pending-response slot. Directed scenarios plus a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_stall_histogram;

    localparam int C  = 2;
    localparam int R  = 8;
    localparam int W  = 4;
    localparam int D  = 8;
    localparam int NC = R + 3;
    localparam int AW = $clog2(R + 3);
    localparam int CW = 1;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic            clk_i = 1'b0;
    logic            reset_li;
    logic [C-1:0]    freeze_i;
    logic [C-1:0]    instret_i;
    logic [C*R-1:0]  stall_reason_i;
    logic            clear_i;
    logic            rd_v_i;
    logic            rd_ready_o;
    logic [CW-1:0]   rd_chan_i;
    logic [AW-1:0]   rd_addr_i;
    logic            rd_data_v_o;
    logic [W-1:0]    rd_data_o;
    logic            rd_err_o;
    logic            rd_yumi_i;
    logic [C-1:0]    overflow_o;

    always #5 clk_i = ~clk_i;

    bp_stall_histogram #(
        .num_channels_p  (C),
        .num_reasons_p   (R),
        .counter_width_p (W),
        .freeze_delay_p  (D)
    ) dut (
        .clk_i          (clk_i),
        .reset_li       (reset_li),
        .freeze_i       (freeze_i),
        .instret_i      (instret_i),
        .stall_reason_i (stall_reason_i),
        .clear_i        (clear_i),
        .rd_v_i         (rd_v_i),
        .rd_ready_o     (rd_ready_o),
        .rd_chan_i      (rd_chan_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_v_o    (rd_data_v_o),
        .rd_data_o      (rd_data_o),
        .rd_err_o       (rd_err_o),
        .rd_yumi_i      (rd_yumi_i),
        .overflow_o     (overflow_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int unsigned m_cnt [C][NC];
    logic [C-1:0] m_ovf;
    int           zero_run [C];   // consecutive unfrozen samples since reset/freeze
    bit           m_rd_v;
    bit           m_rd_err;
    int unsigned  m_rd_data;

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < NC; k++) m_cnt[c][k] = 0;
            zero_run[c] = 0;
        end
        m_ovf     = '0;
        m_rd_v    = 0;
        m_rd_err  = 0;
        m_rd_data = 0;
    endtask

    function automatic void bump(int c, int k);
        if (m_cnt[c][k] == MAXV) begin
`ifdef BP_STALL_HIST_SATURATE_EN
            m_ovf[c] = 1'b1;
`else
            m_cnt[c][k] = 0;
            m_ovf[c]    = 1'b1;
`endif
        end else begin
            m_cnt[c][k] = m_cnt[c][k] + 1;
`ifdef BP_STALL_HIST_SATURATE_EN
            if (m_cnt[c][k] == MAXV) m_ovf[c] = 1'b1;
`endif
        end
    endfunction

    // Advance one clock edge, applying the current inputs to the model,
    // then settle 1ns after the edge.
    task automatic tick();
        bit acc;
        bit bad;
        int low;
        @(posedge clk_i);
        if (!reset_li) begin
            model_reset();
        end else begin
            acc = rd_v_i && (!m_rd_v || rd_yumi_i);
            if (acc) begin
                bad      = (int'(rd_addr_i) > R + 2) || (int'(rd_chan_i) >= C);
                m_rd_v   = 1;
                m_rd_err = bad;
                if (bad) m_rd_data = 0;
                else     m_rd_data = m_cnt[rd_chan_i][rd_addr_i];
            end else if (rd_yumi_i) begin
                m_rd_v = 0;
            end
            for (int c = 0; c < C; c++) begin
                if (clear_i) begin
                    for (int k = 0; k < NC; k++) m_cnt[c][k] = 0;
                    m_ovf[c] = 1'b0;
                end else if (zero_run[c] >= D) begin
                    bump(c, R + 2);
                    if (instret_i[c]) begin
                        bump(c, R + 1);
                    end else begin
                        low = -1;
                        for (int r = R - 1; r >= 0; r--) if (stall_reason_i[c*R + r]) low = r;
                        if (low >= 0) bump(c, low);
                        else          bump(c, R);
                    end
                end
                if (freeze_i[c])     zero_run[c] = 0;
                else if (zero_run[c] < D) zero_run[c] = zero_run[c] + 1;
            end
        end
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one read with yumi for any prior response in the same cycle.
    task automatic do_read(int chan, int addr);
        rd_v_i    = 1'b1;
        rd_yumi_i = 1'b1;
        rd_chan_i = CW'(chan);
        rd_addr_i = AW'(addr);
        tick();
        rd_v_i    = 1'b0;
        rd_yumi_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_li       = 1'b0;
        freeze_i       = '0;
        instret_i      = '0;
        stall_reason_i = '0;
        clear_i        = 1'b0;
        rd_v_i         = 1'b0;
        rd_yumi_i      = 1'b0;
        rd_chan_i      = '0;
        rd_addr_i      = '0;
        model_reset();
        ticks(3);
        n_cmp++; if (rd_data_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_v: got %0b expected 0", rd_data_v_o); end
        n_cmp++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data_o); end
        n_cmp++; if (rd_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err: got %0b expected 0", rd_err_o); end
        n_cmp++; if (overflow_o !== '0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
        n_cmp++; if (rd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", rd_ready_o); end
        @(negedge clk_i);
        reset_li = 1'b1;
    endtask

    task automatic test_cycles_start();
        ticks(20);
        do_read(0, R + 2);
        n_cmp++; if (rd_data_v_o !== 1'b1) begin n_fail++; $display("FAIL cycles_v: got %0b expected 1", rd_data_v_o); end
        n_cmp++; if (rd_data_o !== W'(12)) begin n_fail++; $display("FAIL cycles_start: got %0d expected 12", rd_data_o); end
        n_cmp++; if (rd_data_o !== W'(m_rd_data)) begin n_fail++; $display("FAIL cycles_model: got %0d expected %0d", rd_data_o, m_rd_data); end
        n_cmp++; if (rd_err_o !== 1'b0) begin n_fail++; $display("FAIL cycles_err: got %0b expected 0", rd_err_o); end
    endtask

    task automatic test_reason_priority();
        do_clear();
        stall_reason_i = {8'h80, 8'h14};
        ticks(5);
        stall_reason_i = '0;
        do_read(0, 2);
        n_cmp++; if (rd_data_o !== W'(5)) begin n_fail++; $display("FAIL prio_r2: got %0d expected 5", rd_data_o); end
        do_read(0, 4);
        n_cmp++; if (rd_data_o !== W'(0)) begin n_fail++; $display("FAIL prio_r4: got %0d expected 0", rd_data_o); end
        instret_i      = 2'b01;
        stall_reason_i = {8'h80, 8'h14};
        ticks(3);
        instret_i      = '0;
        stall_reason_i = '0;
        do_read(0, R + 1);
        n_cmp++; if (rd_data_o !== W'(3)) begin n_fail++; $display("FAIL prio_instret: got %0d expected 3", rd_data_o); end
        do_read(0, 2);
        n_cmp++; if (rd_data_o !== W'(5)) begin n_fail++; $display("FAIL prio_r2_masked: got %0d expected 5", rd_data_o); end
        do_read(1, 7);
        n_cmp++; if (rd_data_o !== W'(8)) begin n_fail++; $display("FAIL prio_ch1_r7: got %0d expected 8", rd_data_o); end
    endtask

    task automatic test_unattributed();
        do_clear();
        ticks(4);
        instret_i = 2'b11;
        do_read(0, R);
        instret_i = '0;
        n_cmp++; if (rd_data_o !== W'(4)) begin n_fail++; $display("FAIL unattributed: got %0d expected 4", rd_data_o); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_d;
`ifdef BP_STALL_HIST_SATURATE_EN
        exp_d = W'(15);
`else
        exp_d = W'(4);
`endif
        do_clear();
        stall_reason_i = {8'h00, 8'h01};
        ticks(20);
        stall_reason_i = '0;
        do_read(0, 0);
        n_cmp++; if (rd_data_o !== exp_d) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", rd_data_o, exp_d); end
        n_cmp++; if (overflow_o[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow_o[0]); end
        n_cmp++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL ovf_model: got %0b expected %0b", overflow_o, m_ovf); end
    endtask

    task automatic test_clear_read();
        do_clear();
        stall_reason_i = {8'h00, 8'h08};
        ticks(3);
        clear_i   = 1'b1;
        rd_v_i    = 1'b1;
        rd_yumi_i = 1'b1;
        rd_chan_i = '0;
        rd_addr_i = AW'(3);
        tick();
        clear_i   = 1'b0;
        rd_v_i    = 1'b0;
        rd_yumi_i = 1'b0;
        n_cmp++; if (rd_data_o !== W'(3)) begin n_fail++; $display("FAIL clear_preval: got %0d expected 3", rd_data_o); end
        n_cmp++; if (overflow_o !== '0) begin n_fail++; $display("FAIL clear_ovf: got %0b expected 0", overflow_o); end
        do_read(0, 3);
        stall_reason_i = '0;
        n_cmp++; if (rd_data_o !== W'(0)) begin n_fail++; $display("FAIL clear_postval: got %0d expected 0", rd_data_o); end
    endtask

    task automatic test_back_to_back();
        do_read(1, R + 3);
        n_cmp++; if (rd_err_o !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %0b expected 1", rd_err_o); end
        n_cmp++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL err_data: got %0d expected 0", rd_data_o); end
        rd_v_i    = 1'b1;
        rd_chan_i = 1'b1;
        rd_addr_i = AW'(R + 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rd_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %0b expected 0", rd_ready_o); end
            n_cmp++; if (rd_data_v_o !== 1'b1 || rd_err_o !== 1'b1 || rd_data_o !== '0)
                begin n_fail++; $display("FAIL hold_stable: got v=%0b err=%0b d=%0d expected v=1 err=1 d=0", rd_data_v_o, rd_err_o, rd_data_o); end
        end
        rd_yumi_i = 1'b1;
        #1;
        n_cmp++; if (rd_ready_o !== 1'b1) begin n_fail++; $display("FAIL yumi_ready: got %0b expected 1", rd_ready_o); end
        tick();
        rd_v_i    = 1'b0;
        rd_yumi_i = 1'b0;
        n_cmp++; if (rd_err_o !== 1'b0 || rd_data_v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got v=%0b err=%0b expected v=1 err=0", rd_data_v_o, rd_err_o); end
        n_cmp++; if (rd_data_o !== W'(m_rd_data)) begin n_fail++; $display("FAIL b2b_data: got %0d expected %0d", rd_data_o, m_rd_data); end
    endtask

    task automatic test_reset_mid_read();
        do_read(0, R + 2);
        #2;
        reset_li = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (rd_data_v_o !== 1'b0 || rd_data_o !== '0) begin n_fail++; $display("FAIL async_drop: got v=%0b d=%0d expected v=0 d=0", rd_data_v_o, rd_data_o); end
        ticks(2);
        @(negedge clk_i);
        reset_li = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(0, 29) == 0) freeze_i[c] = ~freeze_i[c];
            end
            instret_i      = C'($urandom_range(0, 3) & $urandom_range(0, 3));
            stall_reason_i = ($urandom_range(0, 3) == 0) ? '0 : (C*R)'($urandom());
            clear_i        = ($urandom_range(0, 59) == 0);
            rd_v_i         = $urandom_range(0, 1);
            rd_yumi_i      = $urandom_range(0, 1);
            rd_chan_i      = CW'($urandom_range(0, 1));
            rd_addr_i      = AW'($urandom_range(0, 15));
            tick();
            n_cmp++; if (rd_data_v_o !== m_rd_v) begin n_fail++; $display("FAIL rnd_v[%0d]: got %0b expected %0b", i, rd_data_v_o, m_rd_v); end
            n_cmp++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %0b expected %0b", i, overflow_o, m_ovf); end
            if (m_rd_v) begin
                n_cmp++; if (rd_data_o !== W'(m_rd_data) || rd_err_o !== m_rd_err)
                    begin n_fail++; $display("FAIL rnd_data[%0d]: got d=%0d err=%0b expected d=%0d err=%0b", i, rd_data_o, rd_err_o, m_rd_data, m_rd_err); end
            end
        end
        freeze_i       = '0;
        instret_i      = '0;
        stall_reason_i = '0;
        clear_i        = 1'b0;
        rd_v_i         = 1'b0;
        rd_yumi_i      = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cycles_start();
        test_reason_priority();
        test_unattributed();
        test_overflow();
        test_clear_read();
        test_back_to_back();
        test_reset_mid_read();
        ticks(10);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
